// File: rtl/vga_layer_compositor.sv
// vga_layer_compositor
//   Parametrised VGA timing generator with an N-layer priority compositor.
//   Issues pixel coordinates to the draw units, accepts their {r,g,b}+dav
//   LAT enabled cycles later, delay-aligns sync/blank with that data and
//   registers the composed pixel onto the VGA pins (LAT+1 cycles after x/y).
//
// Ports
//   clk, rst      pixel clock, synchronous active-high reset
//   pix_en        clock enable for counters, pipeline and output registers
//   layer_mask    per-layer enable, latched on frame_start
//   layer_rgb     per-layer {r,g,b}; layer i at [i*3*CW +: 3*CW]
//   layer_dav     per-layer pixel valid
//   x, y          current pixel coordinates
//   active        x/y inside the visible area (unaligned)
//   line_start    x==0 on an enabled cycle
//   frame_start   x==0 && y==0 on an enabled cycle
//   frame_cnt     completed frames, wrapping
//   vga_hs/vs     aligned sync
//   vga_r/g/b     aligned colour, zero during blank
module vga_layer_compositor #(
  parameter int unsigned    H_ACTIVE = 800,
  parameter int unsigned    H_FP     = 56,
  parameter int unsigned    H_SYNC   = 120,
  parameter int unsigned    H_BP     = 64,
  parameter int unsigned    V_ACTIVE = 600,
  parameter int unsigned    V_FP     = 37,
  parameter int unsigned    V_SYNC   = 6,
  parameter int unsigned    V_BP     = 23,
  parameter bit             HS_POL   = 1'b1,
  parameter bit             VS_POL   = 1'b1,
  parameter int unsigned    N_LAYERS = 4,
  parameter int unsigned    CW       = 2,
  parameter int unsigned    LAT      = 2,
  parameter logic [3*CW-1:0] BG_RGB  = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       pix_en,
  input  logic [N_LAYERS-1:0]        layer_mask,
  input  logic [N_LAYERS*3*CW-1:0]   layer_rgb,
  input  logic [N_LAYERS-1:0]        layer_dav,
  output logic [10:0]                x,
  output logic [9:0]                 y,
  output logic                       active,
  output logic                       line_start,
  output logic                       frame_start,
  output logic [15:0]                frame_cnt,
  output logic                       vga_hs,
  output logic                       vga_vs,
  output logic [CW-1:0]              vga_r,
  output logic [CW-1:0]              vga_g,
  output logic [CW-1:0]              vga_b
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned PW      = 3 * CW;

  localparam logic [10:0] X_LAST   = 11'(H_TOTAL - 1);
  localparam logic [10:0] X_VIS    = 11'(H_ACTIVE);
  localparam logic [10:0] HS_BEGIN = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0]  Y_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0]  Y_VIS    = 10'(V_ACTIVE);
  localparam logic [9:0]  VS_BEGIN = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic               x_last;
  logic               y_last;
  logic               in_vis;
  logic               raw_hs;
  logic               raw_vs;
  logic               raw_blank;
  logic [LAT-1:0]     hs_sr;
  logic [LAT-1:0]     vs_sr;
  logic [LAT-1:0]     blank_sr;
  logic [N_LAYERS-1:0] mask_q;
  logic [PW-1:0]      pick;
  logic [PW-1:0]      rgb_q;

  // ---------------------------------------------------------------------------
  // Timing counters
  // ---------------------------------------------------------------------------
  assign x_last = (x == X_LAST);
  assign y_last = (y == Y_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      x         <= '0;
      y         <= '0;
      frame_cnt <= '0;
    end else if (pix_en) begin
      if (x_last) begin
        x <= '0;
        if (y_last) begin
          y         <= '0;
          frame_cnt <= frame_cnt + 16'd1;
        end else begin
          y <= y + 10'd1;
        end
      end else begin
        x <= x + 11'd1;
      end
    end
  end

  // Status outputs are combinational on the current x/y; gating with rst keeps
  // them quiet while reset is held even before the counters have cleared.
  assign in_vis      = (x < X_VIS) && (y < Y_VIS);
  assign active      = !rst && in_vis;
  assign line_start  = !rst && pix_en && (x == '0);
  assign frame_start = !rst && pix_en && (x == '0) && (y == '0);

  // ---------------------------------------------------------------------------
  // Raw sync / blank for the current x/y
  // ---------------------------------------------------------------------------
  assign raw_hs    = ((x >= HS_BEGIN) && (x < HS_END)) ? HS_POL : ~HS_POL;
  assign raw_vs    = ((y >= VS_BEGIN) && (y < VS_END)) ? VS_POL : ~VS_POL;
  assign raw_blank = !in_vis;

  // ---------------------------------------------------------------------------
  // Alignment shift registers: stage LAT-1 matches the layer data arriving now
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      hs_sr    <= {LAT{~HS_POL}};
      vs_sr    <= {LAT{~VS_POL}};
      blank_sr <= '1;
    end else if (pix_en) begin
      hs_sr[0]    <= raw_hs;
      vs_sr[0]    <= raw_vs;
      blank_sr[0] <= raw_blank;
      for (int unsigned i = 1; i < LAT; i++) begin
        hs_sr[i]    <= hs_sr[i-1];
        vs_sr[i]    <= vs_sr[i-1];
        blank_sr[i] <= blank_sr[i-1];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Per-frame layer mask
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      mask_q <= '1;
    end else if (frame_start) begin
      mask_q <= layer_mask;
    end
  end

  // ---------------------------------------------------------------------------
  // Priority compose: lowest enabled index with dav wins, else background
  // ---------------------------------------------------------------------------
  always_comb begin
    logic found;
    found = 1'b0;
    pick  = BG_RGB;
    for (int unsigned i = 0; i < N_LAYERS; i++) begin
      if (!found && layer_dav[i] && mask_q[i]) begin
        pick  = layer_rgb[i*PW +: PW];
        found = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      vga_hs <= ~HS_POL;
      vga_vs <= ~VS_POL;
      rgb_q  <= '0;
    end else if (pix_en) begin
      vga_hs <= hs_sr[LAT-1];
      vga_vs <= vs_sr[LAT-1];
      rgb_q  <= blank_sr[LAT-1] ? '0 : pick;
    end
  end

  assign vga_r = rgb_q[PW-1 -: CW];
  assign vga_g = rgb_q[2*CW-1 -: CW];
  assign vga_b = rgb_q[CW-1:0];

endmodule

// File: tb/tb_vga_layer_compositor.sv
// Bench for vga_layer_compositor using a reduced 30x15 raster
// (H 16/4/6/4, V 8/2/3/2, LAT 2, BG 6'h2A) so whole frames are short.
module tb_vga_layer_compositor;

  localparam int HT = 30;
  localparam int VT = 15;
  localparam int FT = 450;

  logic        clk = 1'b0;
  logic        rst;
  logic        pix_en;
  logic [3:0]  layer_mask;
  logic [23:0] layer_rgb;
  logic [3:0]  layer_dav;
  logic [10:0] x;
  logic [9:0]  y;
  logic        active;
  logic        line_start;
  logic        frame_start;
  logic [15:0] frame_cnt;
  logic        vga_hs;
  logic        vga_vs;
  logic [1:0]  vga_r;
  logic [1:0]  vga_g;
  logic [1:0]  vga_b;

  always #5 clk = ~clk;

  vga_layer_compositor #(
    .H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(4),
    .V_ACTIVE(8),  .V_FP(2), .V_SYNC(3), .V_BP(2),
    .HS_POL(1'b1), .VS_POL(1'b1),
    .N_LAYERS(4), .CW(2), .LAT(2), .BG_RGB(6'h2A)
  ) dut (
    .clk(clk), .rst(rst), .pix_en(pix_en),
    .layer_mask(layer_mask), .layer_rgb(layer_rgb), .layer_dav(layer_dav),
    .x(x), .y(y), .active(active), .line_start(line_start),
    .frame_start(frame_start), .frame_cnt(frame_cnt),
    .vga_hs(vga_hs), .vga_vs(vga_vs),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference raster: sync columns 20..25, sync rows 10..12, visible 16x8.
  function automatic bit m_hs(input int t);
    int xx;
    xx = t % HT;
    return (xx >= 20) && (xx < 26);
  endfunction

  function automatic bit m_vs(input int t);
    int yy;
    yy = (t / HT) % VT;
    return (yy >= 10) && (yy < 13);
  endfunction

  function automatic bit m_blank(input int t);
    int xx;
    int yy;
    xx = t % HT;
    yy = (t / HT) % VT;
    return !((xx < 16) && (yy < 8));
  endfunction

  function automatic logic [5:0] compose(input logic [3:0] d, input logic [23:0] c,
                                         input logic [3:0] m);
    for (int i = 0; i < 4; i++)
      if (d[i] && m[i]) return c[i*6 +: 6];
    return 6'h2A;
  endfunction

  int         t;
  int         clk_n = 0;
  logic [3:0] mask_m;
  logic [5:0] exp_rgb;
  bit         track;
  int         first_hs;
  int         hs_cnt;
  int         vs_cnt;
  int         fs_prev;
  int         fs_period;
  int         ls_prev_clk;
  int         ls_period_clk;

  // Steps n clocks; toggle=1 enables only every other cycle (first one enabled).
  task automatic run(input int n, input bit toggle);
    for (int i = 0; i < n; i++) begin
      bit         en;
      bit         ls_e;
      bit         fs_e;
      logic [5:0] comp;
      en = toggle ? (i % 2 == 0) : 1'b1;
      pix_en = en;
      #1;
      ls_e = en && (t % HT == 0);
      fs_e = en && (t % FT == 0);
      check("x", x, t % HT);
      check("y", y, (t / HT) % VT);
      check("active", active, !m_blank(t));
      check("line_start", line_start, ls_e);
      check("frame_start", frame_start, fs_e);
      if (ls_e) begin
        if (ls_prev_clk >= 0) ls_period_clk = clk_n - ls_prev_clk;
        ls_prev_clk = clk_n;
      end
      if (fs_e) begin
        if (fs_prev >= 0) fs_period = t - fs_prev;
        fs_prev = t;
      end
      comp = compose(layer_dav, layer_rgb, mask_m);
      @(posedge clk);
      clk_n++;
      #1;
      if (en) begin
        if (fs_e) mask_m = layer_mask;
        t++;
        exp_rgb = (t < 3 || m_blank(t - 3)) ? 6'h00 : comp;
      end
      check("vga_hs", vga_hs, (t >= 3) ? m_hs(t - 3) : 1'b0);
      check("vga_vs", vga_vs, (t >= 3) ? m_vs(t - 3) : 1'b0);
      check("rgb", {vga_r, vga_g, vga_b}, exp_rgb);
      check("frame_cnt", frame_cnt, t / FT);
      if (track && en) begin
        if (vga_hs && first_hs < 0) first_hs = t;
        if (vga_hs) hs_cnt++;
        if (vga_vs) vs_cnt++;
      end
    end
  endtask

  task automatic restart_model();
    t       = 0;
    mask_m  = 4'hF;
    exp_rgb = 6'h00;
  endtask

  initial begin
    rst        = 1'b1;
    pix_en     = 1'b1;
    layer_mask = 4'hF;
    layer_dav  = 4'h0;
    layer_rgb  = {6'h15, 6'h2A, 6'h3F, 6'h01};
    first_hs = -1; hs_cnt = 0; vs_cnt = 0;
    fs_prev = -1; fs_period = -1; ls_prev_clk = -1; ls_period_clk = -1;
    track = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_x", x, 0);
    check("rst_y", y, 0);
    check("rst_hs", vga_hs, 1'b0);
    check("rst_vs", vga_vs, 1'b0);
    check("rst_rgb", {vga_r, vga_g, vga_b}, 6'h00);
    check("rst_active", active, 1'b0);
    check("rst_line_start", line_start, 1'b0);
    check("rst_frame_start", frame_start, 1'b0);
    check("rst_frame_cnt", frame_cnt, 0);

    // One frame plus a bit, no layer data: background in the visible area
    rst = 1'b0;
    restart_model();
    track = 1'b1;
    run(460, 1'b0);
    track = 1'b0;
    check("first_hs_cycle", first_hs, 23);
    check("hs_cycles_15_lines", hs_cnt, 90);
    check("vs_cycles", vs_cnt, 90);
    check("frame_period", fs_period, FT);
    check("line_period", ls_period_clk, HT);
    check("frame_cnt_after_frame", frame_cnt, 1);

    // Priority: dav 1010 -> layer 1 (3F); masked later -> layer 3 (15)
    layer_dav = 4'b1010;
    run(28, 1'b0);
    check("prio_layer1", {vga_r, vga_g, vga_b}, 6'h3F);
    layer_mask = 4'b1101;
    run(190, 1'b0);
    check("mask_pending_still_3F", {vga_r, vga_g, vga_b}, 6'h3F);
    run(260, 1'b0);
    check("mask_applied_15", {vga_r, vga_g, vga_b}, 6'h15);

    // Half-rate enable: every other clock
    ls_prev_clk   = -1;
    ls_period_clk = -1;
    run(140, 1'b1);
    check("line_period_toggle", ls_period_clk, 2 * HT);

    // Mid-frame reset while the hs pin is asserted
    layer_dav = 4'b1111;
    run(8, 1'b0);
    check("hs_before_rst", vga_hs, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_hs", vga_hs, 1'b0);
    check("midrst_vs", vga_vs, 1'b0);
    check("midrst_rgb", {vga_r, vga_g, vga_b}, 6'h00);
    check("midrst_x", x, 0);
    check("midrst_active", active, 1'b0);
    check("midrst_frame_start", frame_start, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    restart_model();
    run(22, 1'b0);
    check("blank_forces_zero", {vga_r, vga_g, vga_b}, 6'h00);
    run(18, 1'b0);
    check("all_dav_layer0", {vga_r, vga_g, vga_b}, 6'h01);
    check("frame_cnt_after_rst", frame_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
